// File: rtl/vga_timing_pkg.sv
// Shared types and default 1024x768@70Hz timing for the VGA sync generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_e;

    typedef enum logic {
        WAIT_ALIGN,
        RUN
    } top_state_e;

    localparam int unsigned DEF_COUNTER_SIZE = 11;
    localparam int unsigned DEF_H_ACTIVE     = 1024;
    localparam int unsigned DEF_H_FRONT      = 24;
    localparam int unsigned DEF_H_SYNC       = 136;
    localparam int unsigned DEF_H_TOTAL      = 1328;
    localparam int unsigned DEF_V_ACTIVE     = 768;
    localparam int unsigned DEF_V_FRONT      = 3;
    localparam int unsigned DEF_V_SYNC       = 6;
    localparam int unsigned DEF_V_TOTAL      = 806;

    // Upstream counter's threshold flag fires at this h_count value.
    localparam int unsigned UPSTREAM_THRESHOLD = 1072;

endpackage

// File: rtl/axis_phase_tracker.sv
// Classifies one timing axis count into ACTIVE/FRONT/SYNC/BACK and registers the phase.
module axis_phase_tracker
    import vga_timing_pkg::*;
#(
    parameter int unsigned W = 11,
    parameter int unsigned A = 1024,
    parameter int unsigned F = 24,
    parameter int unsigned S = 136,
    parameter int unsigned T = 1328
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [W-1:0] count,
    output phase_e       phase_c,
    output logic         in_sync
);

    localparam logic [W-1:0] B_FRONT = W'(A);
    localparam logic [W-1:0] B_SYNC  = W'(A + F);
    localparam logic [W-1:0] B_BACK  = W'(A + F + S);
    localparam logic [W-1:0] B_END   = W'(T);

    phase_e phase_d;
    phase_e phase_q;

    // Out-of-range counts fall into BACK so they read as blanking without sync.
    always_comb begin
        phase_c = PH_BACK;
        if (count >= B_END) begin
            phase_c = PH_BACK;
        end else if (count < B_FRONT) begin
            phase_c = PH_ACTIVE;
        end else if (count < B_SYNC) begin
            phase_c = PH_FRONT;
        end else if (count < B_BACK) begin
            phase_c = PH_SYNC;
        end
    end

    always_comb begin
        phase_d = PH_ACTIVE;
        if (enable) begin
            phase_d = phase_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_ACTIVE;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign in_sync = (phase_q == PH_SYNC);

endmodule

// File: rtl/vga_sync_generator.sv
// Aligns to a free-running horizontal counter and produces registered VGA sync, video and strobe outputs.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE    = DEF_COUNTER_SIZE,
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT         = DEF_H_FRONT,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_TOTAL         = DEF_H_TOTAL,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT         = DEF_V_FRONT,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_TOTAL         = DEF_V_TOTAL,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                    control_clock,
    input  logic                    reset,
    input  logic [COUNTER_SIZE-1:0] h_count,
    input  logic                    h_zero,
    input  logic                    h_threshold,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    video_on,
    output logic [COUNTER_SIZE-1:0] pixel_x,
    output logic [COUNTER_SIZE-1:0] pixel_y,
    output logic                    line_start,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    range_error
);

    localparam logic [COUNTER_SIZE-1:0] H_LAST   = COUNTER_SIZE'(H_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] H_END    = COUNTER_SIZE'(H_TOTAL);
    localparam logic [COUNTER_SIZE-1:0] V_LAST   = COUNTER_SIZE'(V_TOTAL - 1);
    localparam logic [COUNTER_SIZE-1:0] H_THRESH = COUNTER_SIZE'(UPSTREAM_THRESHOLD);
    localparam logic                    SYNC_INV = 1'(SYNC_ACTIVE_LOW != 0);

    top_state_e              state_d, state_q;
    logic [COUNTER_SIZE-1:0] v_count_d, v_count_q;
    logic [COUNTER_SIZE-1:0] pixel_x_d, pixel_x_q;
    logic [COUNTER_SIZE-1:0] pixel_y_d, pixel_y_q;
    logic                    video_on_d, video_on_q;
    logic                    line_start_d, line_start_q;
    logic                    frame_start_d, frame_start_q;
    logic                    locked_d, locked_q;
    logic                    range_error_d, range_error_q;

    logic   run_c;
    logic   h_zero_c;
    phase_e h_phase_c, v_phase_c;
    logic   h_in_sync, v_in_sync;

    // The aligning cycle itself is already described as line 0, pixel 0.
    assign run_c    = (state_q == RUN) || h_zero;
    assign h_zero_c = (h_count == '0);

    axis_phase_tracker #(
        .W (COUNTER_SIZE),
        .A (H_ACTIVE),
        .F (H_FRONT),
        .S (H_SYNC),
        .T (H_TOTAL)
    ) u_h_phase (
        .clk     (control_clock),
        .rst     (reset),
        .enable  (run_c),
        .count   (h_count),
        .phase_c (h_phase_c),
        .in_sync (h_in_sync)
    );

    axis_phase_tracker #(
        .W (COUNTER_SIZE),
        .A (V_ACTIVE),
        .F (V_FRONT),
        .S (V_SYNC),
        .T (V_TOTAL)
    ) u_v_phase (
        .clk     (control_clock),
        .rst     (reset),
        .enable  (run_c),
        .count   (v_count_q),
        .phase_c (v_phase_c),
        .in_sync (v_in_sync)
    );

    always_comb begin
        state_d       = state_q;
        v_count_d     = v_count_q;
        range_error_d = range_error_q;
        unique case (state_q)
            WAIT_ALIGN: begin
                if (h_zero) begin
                    state_d   = RUN;
                    v_count_d = '0;
                end
            end
            RUN: begin
                if (h_count == H_LAST) begin
                    v_count_d = (v_count_q == V_LAST) ? '0 : v_count_q + COUNTER_SIZE'(1);
                end
                if ((h_count >= H_END) || (h_zero && !h_zero_c) ||
                    (h_threshold != (h_count == H_THRESH))) begin
                    range_error_d = 1'b1;
                end
            end
            default: state_d = WAIT_ALIGN;
        endcase
    end

    always_comb begin
        video_on_d    = run_c && (h_phase_c == PH_ACTIVE) && (v_phase_c == PH_ACTIVE);
        pixel_x_d     = video_on_d ? h_count : '0;
        pixel_y_d     = video_on_d ? v_count_q : '0;
        line_start_d  = run_c && h_zero_c;
        frame_start_d = line_start_d && (v_count_q == '0);
        locked_d      = (state_d == RUN);
    end

    always_ff @(posedge control_clock or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_ALIGN;
            v_count_q     <= '0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            range_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_count_q     <= v_count_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            range_error_q <= range_error_d;
        end
    end

    assign hsync       = h_in_sync ^ SYNC_INV;
    assign vsync       = v_in_sync ^ SYNC_INV;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign range_error = range_error_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench for vga_sync_generator with a shortened vertical frame (10 lines).
module tb_vga_sync_generator;

    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VT = 10;
    localparam int HT = 1328;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vid;
        logic [10:0] px;
        logic [10:0] py;
        logic        ls;
        logic        fs;
        logic        lk;
        logic        err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h_count;
    logic        h_zero;
    logic        h_threshold;
    logic        hsync, vsync, video_on, line_start, frame_start, locked, range_error;
    logic [10:0] pixel_x, pixel_y;

    vga_sync_generator #(
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_TOTAL  (VT)
    ) dut (
        .control_clock (clk),
        .reset         (rst),
        .h_count       (h_count),
        .h_zero        (h_zero),
        .h_threshold   (h_threshold),
        .hsync         (hsync),
        .vsync         (vsync),
        .video_on      (video_on),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .line_start    (line_start),
        .frame_start   (frame_start),
        .locked        (locked),
        .range_error   (range_error)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Monitor-side statistics, cleared by the stimulus between windows.
    int cyc = 0;
    int n_vid, n_hs_low, n_vs_low, n_ls, n_fs, max_py;
    int fs_prev = -1;
    int fs_last = -1;

    // Bench model of the block's state.
    bit m_locked = 1'b0;
    int m_v      = 0;
    bit m_err    = 1'b0;

    int up_h;
    bit rst_lvl;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cnt_clear();
        n_vid = 0; n_hs_low = 0; n_vs_low = 0; n_ls = 0; n_fs = 0; max_py = 0;
    endtask

    // Drive one cycle of inputs and push what the outputs must show after the next edge.
    task automatic drive(input bit r, input int h, input bit z, input bit t);
        obs_t e;
        bit   run;
        int   veff;
        @(negedge clk);
        rst = r; h_count = 11'(h); h_zero = z; h_threshold = t;
        e = '0;
        if (r) begin
            m_locked = 1'b0; m_v = 0; m_err = 1'b0;
            e.hs = 1'b1; e.vs = 1'b1;
        end else begin
            run  = m_locked || z;
            veff = m_locked ? m_v : 0;
            e.vid = run && (h < 1024) && (veff < VA);
            e.px  = e.vid ? 11'(h) : 11'd0;
            e.py  = e.vid ? 11'(veff) : 11'd0;
            e.hs  = !(run && h >= 1048 && h < 1184);
            e.vs  = !(run && veff >= VA + VF && veff < VA + VF + VS);
            e.ls  = run && (h == 0);
            e.fs  = e.ls && (veff == 0);
            if (m_locked && (h >= HT || (z && h != 0) || (t != (h == 1072)))) m_err = 1'b1;
            e.err = m_err;
            if (m_locked && h == HT - 1) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            if (!m_locked && z) begin
                m_locked = 1'b1;
                m_v = 0;
            end
            e.lk = m_locked;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        drive(rst_lvl, up_h, up_h == 0, up_h == 1072);
        up_h = (up_h == HT - 1) ? 0 : up_h + 1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sync_pe();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    initial begin
        obs_t e, a;
        cnt_clear();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            a = '{hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start, locked, range_error};
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL cycle%0d actual={hs%b vs%b vid%b x%0d y%0d ls%b fs%b lk%b err%b} required={hs%b vs%b vid%b x%0d y%0d ls%b fs%b lk%b err%b}",
                             cyc, a.hs, a.vs, a.vid, a.px, a.py, a.ls, a.fs, a.lk, a.err,
                             e.hs, e.vs, e.vid, e.px, e.py, e.ls, e.fs, e.lk, e.err);
                end
            end
            if (video_on)    n_vid++;
            if (!hsync)      n_hs_low++;
            if (!vsync)      n_vs_low++;
            if (line_start)  n_ls++;
            if (frame_start) begin
                n_fs++;
                fs_prev = fs_last;
                fs_last = cyc;
            end
            if (int'(pixel_y) > max_py) max_py = int'(pixel_y);
        end
    end

    initial begin
        rst = 1'b1; h_count = '0; h_zero = 1'b0; h_threshold = 1'b0;
        rst_lvl = 1'b1;
        up_h = 200;

        // Reset held while the upstream counter sweeps.
        run_ticks(300);
        sync_pe();
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_video_on", int'(video_on), 0);
        chk("rst_locked", int'(locked), 0);

        // Release at h_count 500; nothing happens until h_count wraps to 0.
        rst_lvl = 1'b0;
        cnt_clear();
        run_ticks(HT - 500);
        sync_pe();
        chk("prelock_locked", int'(locked), 0);
        chk("prelock_fs_count", n_fs, 0);
        tick();
        sync_pe();
        chk("lock_locked", int'(locked), 1);
        chk("lock_frame_start", int'(frame_start), 1);
        chk("lock_video_on", int'(video_on), 1);

        // Finish line 0, then measure a whole active line (line 1).
        run_ticks(HT - 1);
        sync_pe();
        cnt_clear();
        run_ticks(HT);
        sync_pe();
        chk("line_video_cycles", n_vid, 1024);
        chk("line_hsync_low", n_hs_low, 136);
        chk("line_start_count", n_ls, 1);
        chk("line_vsync_low", n_vs_low, 0);

        // Lines 2..9, then one full frame window.
        run_ticks((VT - 2) * HT);
        sync_pe();
        cnt_clear();
        run_ticks(VT * HT);
        sync_pe();
        chk("frame_video_cycles", n_vid, VA * 1024);
        chk("frame_vsync_low", n_vs_low, VS * HT);
        chk("frame_line_starts", n_ls, VT);
        chk("frame_starts", n_fs, 1);
        chk("frame_max_pixel_y", max_py, VA - 1);
        chk("frame_period", fs_last - fs_prev, VT * HT);
        chk("wrap_last_fs", int'(frame_start), 0);

        // Frame wrap: next h_count 0 is line 0 again.
        tick();
        sync_pe();
        chk("wrap_frame_start", int'(frame_start), 1);
        chk("wrap_pixel_y", int'(pixel_y), 0);
        chk("wrap_video_on", int'(video_on), 1);

        // Out-of-range injection on line 2, pixel 100.
        run_ticks((HT - 1) + HT + 100);
        drive(1'b0, 1400, 1'b0, 1'b0);
        up_h = up_h + 1;
        sync_pe();
        chk("oor_video_on", int'(video_on), 0);
        chk("oor_hsync", int'(hsync), 1);
        chk("oor_range_error", int'(range_error), 1);
        tick();
        sync_pe();
        chk("oor_after_pixel_y", int'(pixel_y), 2);
        chk("oor_after_pixel_x", int'(pixel_x), 101);
        chk("oor_sticky", int'(range_error), 1);

        // Reset mid-frame at line 3, pixel 300.
        run_ticks((HT - 102) + 300);
        rst_lvl = 1'b1;
        tick();
        #1;
        chk("midrst_video_on", int'(video_on), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_range_error", int'(range_error), 0);
        chk("midrst_hsync", int'(hsync), 1);
        run_ticks(4);
        rst_lvl = 1'b0;
        sync_pe();
        cnt_clear();
        run_ticks(HT - up_h);
        sync_pe();
        chk("relock_wait_locked", int'(locked), 0);
        chk("relock_wait_fs", n_fs, 0);
        tick();
        sync_pe();
        chk("relock_locked", int'(locked), 1);
        chk("relock_frame_start", int'(frame_start), 1);
        chk("relock_pixel_y", int'(pixel_y), 0);
        chk("relock_range_error", int'(range_error), 0);
        run_ticks(HT);
        sync_pe();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Consumes the free-running horizontal pixel counter and its zero and threshold flags.
- Maintains its own vertical line counter and horizontal/vertical phase state machines.
- Produces registered hsync, vsync, video_on, pixel coordinates and frame/line strobes for the pixel-data stage and the DAC pins.
- Defaults match 1024x768@70Hz timing: H total 1328 and V total 806.

Parameters:
COUNTER_SIZE, 11, width of h_count and of the internal line counter
H_ACTIVE, 1024, visible pixels per line
H_FRONT, 24, horizontal front porch, pixels
H_SYNC, 136, horizontal sync width, pixels
H_TOTAL, 1328, pixels per line; must equal the upstream counter's wrap value
V_ACTIVE, 768, visible lines
V_FRONT, 3, vertical front porch, lines
V_SYNC, 6, vertical sync width, lines
V_TOTAL, 806, lines per frame
SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0 while asserted

Ports:
control_clock  input  1  pixel clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
h_count  input  COUNTER_SIZE  horizontal counter value from upstream
h_zero  input  1  upstream zero-detect flag (h_count == 0)
h_threshold  input  1  upstream threshold flag, unused for timing, sampled for check only
hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
video_on  output  1  high when pixel is in both active regions
pixel_x  output  COUNTER_SIZE  column, valid while video_on, else 0
pixel_y  output  COUNTER_SIZE  row, valid while video_on, else 0
line_start  output  1  one-cycle pulse at h_count 0 once locked
frame_start  output  1  one-cycle pulse at h_count 0 of line 0 once locked
locked  output  1  high once aligned to upstream counter
range_error  output  1  sticky, h_count >= H_TOTAL seen while locked

Behaviour:
- Reset (async assert, sync release):
  - hsync and vsync at their inactive level (1 if SYNC_ACTIVE_LOW).
  - video_on, line_start, frame_start, locked and range_error = 0.
  - pixel_x, pixel_y and v_count = 0.
  - Top FSM = WAIT_ALIGN.
- The upstream counter has no reset, so this block must align to it.
- Top FSM:
  - WAIT_ALIGN: all outputs stay at their reset values. When a cycle has h_zero = 1, go to RUN, load v_count = 0 and set locked.
  - RUN: normal operation. Stays in RUN until reset.
- Per-axis phase FSM (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE). Boundaries use the axis count c:
  - ACTIVE for c < A.
  - FRONT for A <= c < A+F.
  - SYNC for A+F <= c < A+F+S.
  - BACK for A+F+S <= c < T.
- Horizontal axis: c = h_count.
- Vertical axis: c = v_count.
  - v_count increments in the cycle where h_count == H_TOTAL-1.
  - At V_TOTAL-1 it wraps to 0 instead.
  - Wrap-around of both counters in the same cycle (end of frame) gives v_count = 0 on the next line.
- Latency: all outputs are registered, one cycle after the h_count they describe. Example: h_count = 0 on line 0 gives frame_start = 1 in the following cycle.
- video_on = (h phase ACTIVE) AND (v phase ACTIVE). pixel_x = h_count and pixel_y = v_count when video_on, else 0.
- hsync asserted in h SYNC phase on every line. vsync asserted for the whole of every line whose v_count is in v SYNC phase.
- Out-of-range h_count (>= H_TOTAL) while in RUN:
  - Set range_error and hold it until reset.
  - Treat the cycle as horizontal blanking: video_on = 0, hsync inactive, v_count unchanged.
- h_zero = 1 while h_count != 0 while in RUN: set range_error. h_count is authoritative.
- h_threshold consistency check: while in RUN, h_threshold is compared against the upstream threshold value (no parameter in this block; taken as 1072, the upstream default). A mismatch sets range_error.
- Reset mid-frame: immediate return to reset values; WAIT_ALIGN re-entered on release.

Decomposition:
- Package vga_timing_pkg holds:
  - phase enum (PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK);
  - top-state enum (WAIT_ALIGN, RUN);
  - default 1024x768@70 timing constants.
- Sub-module axis_phase_tracker (params A, F, S, T) outputs phase and in_sync for one axis.
  - Instantiated twice: horizontal fed by h_count, vertical fed by v_count.
  - Registered phase transitions.

Test Plan:
- Reset held, h_count sweeping -> hsync = vsync = 1, video_on = 0, locked = 0. After release with h_count starting at 500, locked stays 0 until the cycle after h_count = 0 -> then locked = 1 and frame_start pulses once.
- Full line after lock -> video_on high for exactly 1024 cycles. hsync low from the cycle after h_count = 1048 through the cycle after h_count = 1183 (136 cycles). line_start pulses once per 1328 cycles.
- Full frame -> vsync low for lines 771..776 (6 × 1328 cycles). pixel_y reaches 767 then video_on stays 0 for lines 768..805. frame_start period = 806 × 1328 = 1070368 cycles.
- Frame wrap -> at h_count = 1327 with v_count = 805, the next line reports pixel_y = 0 with video_on and frame_start = 1 one cycle after h_count = 0.
- Inject h_count = 1400 for one cycle in RUN -> video_on = 0 and hsync inactive that cycle (registered), range_error = 1 and stays 1, v_count unchanged.
- Assert reset at line 400, pixel 300 -> outputs at reset values immediately. After release, relock on the next h_zero with pixel_y restarting at 0.
